// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard scheduler for the D/E/M/W pipeline.
// Tracks each in-flight destination register and its Tnew countdown, raises a
// stall when a D-stage source cannot be satisfied in time, and drives the
// operand-forwarding select codes at D and at E.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic [4:0]       d_wa,
  input  logic [1:0]       d_tnew,
  output logic             stall,
  output logic [1:0]       fwd_d_rs_sel,
  output logic [1:0]       fwd_d_rt_sel,
  output logic [1:0]       fwd_e_rs_sel,
  output logic [1:0]       fwd_e_rt_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned TN_W  = 2;

  localparam logic [1:0] SEL_BASE  = 2'b00;
  localparam logic [1:0] SEL_M     = 2'b01;
  localparam logic [1:0] SEL_W     = 2'b10;
  localparam logic [1:0] TUSE_NONE = 2'b11;

  // E-stage record: sources are kept so E-stage forwarding can be resolved
  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] wa;
    logic [TN_W-1:0]  tnew;
  } e_rec_t;

  // M-stage record: only the destination and the remaining Tnew matter
  typedef struct packed {
    logic [REG_W-1:0] wa;
    logic [TN_W-1:0]  tnew;
  } m_rec_t;

  localparam e_rec_t E_BUBBLE = '{rs: '0, rt: '0, wa: '0, tnew: '0};

  e_rec_t           r_e;
  m_rec_t           r_m;
  logic [REG_W-1:0] r_w_wa;
  logic [CNT_W-1:0] r_stall_cnt;

  e_rec_t           w_e_next;
  m_rec_t           w_m_next;
  logic             w_hazard_rs;
  logic             w_hazard_rt;
  logic             w_stall;
  logic             w_cnt_sat;

  // A producer at (wa, tnew) blocks src if its value will not be ready by tuse
  function automatic logic f_late(
    input logic [REG_W-1:0] wa,
    input logic [TN_W-1:0]  tnew,
    input logic [REG_W-1:0] src,
    input logic [TN_W-1:0]  tuse
  );
    return (wa == src) && (tnew > tuse);
  endfunction

  // RAW hazard for one D-stage source against the E and M records
  function automatic logic f_hazard(
    input logic             valid,
    input logic [REG_W-1:0] src,
    input logic [TN_W-1:0]  tuse,
    input e_rec_t           e,
    input m_rec_t           m
  );
    logic hit;
    hit = f_late(e.wa, e.tnew, src, tuse) || f_late(m.wa, m.tnew, src, tuse);
    return valid && (src != '0) && (tuse != TUSE_NONE) && hit;
  endfunction

  // Forward select: M wins over W when both match (M holds the newer value)
  function automatic logic [1:0] f_fwd_sel(
    input logic [REG_W-1:0] src,
    input m_rec_t           m,
    input logic [REG_W-1:0] w_wa
  );
    logic [1:0] sel;
    sel = SEL_BASE;
    if (src != '0) begin
      if ((m.wa == src) && (m.tnew == '0)) begin
        sel = SEL_M;
      end else if (w_wa == src) begin
        sel = SEL_W;
      end
    end
    return sel;
  endfunction

  // Stall decision from the D-stage sources against in-flight producers
  always_comb begin
    w_hazard_rs = f_hazard(d_valid, d_rs, d_tuse_rs, r_e, r_m);
    w_hazard_rt = f_hazard(d_valid, d_rt, d_tuse_rt, r_e, r_m);
    w_stall     = w_hazard_rs || w_hazard_rt;
  end

  // Forward selects at D and at E; an E-stage match is covered by the stall
  always_comb begin
    fwd_d_rs_sel = f_fwd_sel(d_rs,   r_m, r_w_wa);
    fwd_d_rt_sel = f_fwd_sel(d_rt,   r_m, r_w_wa);
    fwd_e_rs_sel = f_fwd_sel(r_e.rs, r_m, r_w_wa);
    fwd_e_rt_sel = f_fwd_sel(r_e.rt, r_m, r_w_wa);
  end

  // Next E record: bubble on stall or empty D, Tnew floored at 1 (no E->D path)
  always_comb begin
    w_e_next = E_BUBBLE;
    if (d_valid && !w_stall) begin
      w_e_next.rs   = d_rs;
      w_e_next.rt   = d_rt;
      w_e_next.wa   = d_wa;
      w_e_next.tnew = (d_tnew == '0) ? TN_W'(1) : d_tnew;
    end
  end

  // Next M record: E advances with its Tnew counted down, saturating at 0
  always_comb begin
    w_m_next.wa   = r_e.wa;
    w_m_next.tnew = (r_e.tnew == '0) ? '0 : (r_e.tnew - TN_W'(1));
  end

  assign w_cnt_sat = &r_stall_cnt;

  // Stage records shift one stage per clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e    <= E_BUBBLE;
      r_m    <= '0;
      r_w_wa <= '0;
    end else begin
      r_e    <= w_e_next;
      r_m    <= w_m_next;
      r_w_wa <= r_m.wa;
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule
